// File: rtl/bsg_tag_rx_pkg.sv
// Shared types and default widths for the serial tag receiver.
// Holds the decoder FSM state encoding and the saturating abort-count helper.
package bsg_tag_rx_pkg;

  localparam int id_width_default_lp      = 4;
  localparam int len_width_default_lp     = 6;
  localparam int payload_width_default_lp = 8;
  localparam int abort_cnt_width_lp       = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ID      = 3'd1,
    DNR     = 3'd2,
    LEN     = 3'd3,
    PAYLOAD = 3'd4
  } state_e;

  function automatic logic [abort_cnt_width_lp-1:0] sat_inc(input logic [abort_cnt_width_lp-1:0] v);
    return (&v) ? v : v + abort_cnt_width_lp'(1);
  endfunction

endpackage

// File: rtl/bsg_tag_rx_decoder_if.sv
// Serial tag input pair plus decoded outputs of one tag receive node.
// master drives the serial line and observes; slave is the decoder.
interface bsg_tag_rx_decoder_if
  import bsg_tag_rx_pkg::*;
#(
  parameter int payload_width_p = payload_width_default_lp
);

  logic                          tdi_i;
  logic                          tms_i;
  logic [payload_width_p-1:0]    data_o;
  logic                          data_v_o;
  logic                          node_reset_o;
  logic                          busy_o;
  logic [abort_cnt_width_lp-1:0] abort_cnt_o;

  modport master (
    output tdi_i, tms_i,
    input  data_o, data_v_o, node_reset_o, busy_o, abort_cnt_o
  );

  modport slave (
    input  tdi_i, tms_i,
    output data_o, data_v_o, node_reset_o, busy_o, abort_cnt_o
  );

endinterface

// File: rtl/bsg_tag_rx_field_counter.sv
// Loadable down-counter for field bit counts; zero marks the last bit of a field.
// Holds at zero rather than wrapping.
module bsg_tag_rx_field_counter #(
  parameter int width_p = 6
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load,
  input  logic [width_p-1:0] load_val,
  input  logic               dec,
  output logic               zero
);

  logic [width_p-1:0] count;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - width_p'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/bsg_tag_rx_decoder.sv
// Serial tag packet decoder: start, ID, DNR, LEN, payload, all MSB-first.
// Outputs update the cycle after the last bit; the FSM is idle again in that cycle.
module bsg_tag_rx_decoder
  import bsg_tag_rx_pkg::*;
#(
  parameter int node_id_p       = 0,
  parameter int id_width_p      = id_width_default_lp,
  parameter int len_width_p     = len_width_default_lp,
  parameter int payload_width_p = payload_width_default_lp
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  bsg_tag_rx_decoder_if.slave  bus
);

  localparam int cnt_width_lp = (id_width_p > len_width_p) ? id_width_p : len_width_p;

  state_e state, state_n;

  logic                          tdi, tms;
  logic [id_width_p-1:0]         id_sr, id_full;
  logic                          dnr;
  logic [len_width_p-1:0]        len_sr, len_full;
  logic [payload_width_p-1:0]    shadow, shadow_n, done_data;
  logic [payload_width_p-1:0]    data_r;
  logic                          data_v_r, node_reset_r;
  logic [abort_cnt_width_lp-1:0] abort_cnt;
  logic                          id_match;

  logic                    cnt_load, cnt_dec, cnt_zero;
  logic [cnt_width_lp-1:0] cnt_load_val;
  logic                    start, abort, done;
  logic                    shift_id, shift_dnr, shift_len, shift_pl;

  assign tdi = bus.tdi_i;
  assign tms = bus.tms_i;

  // Fields are assembled including the bit on the wire this cycle.
  assign id_full   = (id_sr << 1)  | id_width_p'(tdi);
  assign len_full  = (len_sr << 1) | len_width_p'(tdi);
  assign shadow_n  = (shadow << 1) | payload_width_p'(tdi);
  assign done_data = (state == PAYLOAD) ? shadow_n : shadow;
  assign id_match  = (id_sr == id_width_p'(node_id_p));

  bsg_tag_rx_field_counter #(
    .width_p (cnt_width_lp)
  ) field_counter (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    done         = 1'b0;
    shift_id     = 1'b0;
    shift_dnr    = 1'b0;
    shift_len    = 1'b0;
    shift_pl     = 1'b0;

    if (state != IDLE && !tms) begin
      state_n = IDLE;
      abort   = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (tms && tdi) begin
            state_n      = ID;
            start        = 1'b1;
            cnt_load     = 1'b1;
            cnt_load_val = cnt_width_lp'(id_width_p - 1);
          end
        end
        ID: begin
          shift_id = 1'b1;
          if (cnt_zero) state_n = DNR;
          else          cnt_dec = 1'b1;
        end
        DNR: begin
          shift_dnr    = 1'b1;
          state_n      = LEN;
          cnt_load     = 1'b1;
          cnt_load_val = cnt_width_lp'(len_width_p - 1);
        end
        LEN: begin
          shift_len = 1'b1;
          if (!cnt_zero) begin
            cnt_dec = 1'b1;
          end else if (len_full == '0) begin
            state_n = IDLE;
            done    = 1'b1;
          end else begin
            state_n      = PAYLOAD;
            cnt_load     = 1'b1;
            cnt_load_val = cnt_width_lp'(len_full) - cnt_width_lp'(1);
          end
        end
        PAYLOAD: begin
          shift_pl = 1'b1;
          if (cnt_zero) begin
            state_n = IDLE;
            done    = 1'b1;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      id_sr        <= '0;
      dnr          <= 1'b0;
      len_sr       <= '0;
      shadow       <= '0;
      data_r       <= '0;
      data_v_r     <= 1'b0;
      node_reset_r <= 1'b0;
      abort_cnt    <= '0;
    end else begin
      data_v_r     <= 1'b0;
      node_reset_r <= 1'b0;
      if (start) begin
        id_sr  <= '0;
        dnr    <= 1'b0;
        len_sr <= '0;
        shadow <= '0;
      end
      if (shift_id)  id_sr  <= id_full;
      if (shift_dnr) dnr    <= tdi;
      if (shift_len) len_sr <= len_full;
      if (shift_pl)  shadow <= shadow_n;
      if (done && id_match) begin
        if (dnr) begin
          data_r   <= done_data;
          data_v_r <= 1'b1;
        end else begin
          data_r       <= '0;
          node_reset_r <= 1'b1;
        end
      end
      if (abort) abort_cnt <= sat_inc(abort_cnt);
    end
  end

  assign bus.data_o       = data_r;
  assign bus.data_v_o     = data_v_r;
  assign bus.node_reset_o = node_reset_r;
  assign bus.busy_o       = (state != IDLE);
  assign bus.abort_cnt_o  = abort_cnt;

endmodule

// File: doc/bsg_tag_rx_decoder.md
BSG_TAG_RX_DECODER -- requirements
Module: bsg_tag_rx_decoder

Interface
REQ-001 SHALL have parameter node_id_p, default 0: tag node address this decoder answers to.
REQ-002 SHALL have parameter id_width_p, default 4: width of the node-ID field.
REQ-003 SHALL have parameter len_width_p, default 6: width of the payload-length field.
REQ-004 SHALL have parameter payload_width_p, default 8: width of the data_o register.
REQ-005 SHALL have port clk_i  input  1  tag clock (TCK domain); one clock; all logic on its rising edge.
REQ-006 SHALL have port reset_i  input  1  synchronous, active-high reset.
REQ-007 SHALL have port tdi_i  input  1  serial tag data.
REQ-008 SHALL have port tms_i  input  1  frame enable; bits are meaningful only while high.
REQ-009 SHALL have port data_o  output  payload_width_p  last accepted payload, registered.
REQ-010 SHALL have port data_v_o  output  1  one-cycle pulse: data_o just updated.
REQ-011 SHALL have port node_reset_o  output  1  one-cycle pulse: reset packet accepted.
REQ-012 SHALL have port busy_o  output  1  high whenever the FSM is not in IDLE.
REQ-013 SHALL have port abort_cnt_o  output  8  saturating count of aborted packets.

Function
REQ-014 Packet format SHALL be, one bit per cycle: start bit 1, ID (id_width_p bits), DNR (1 bit: 1=data, 0=reset), LEN (len_width_p bits), payload (LEN bits); all fields MSB-first.
REQ-015 FSM states SHALL be IDLE, ID, DNR, LEN, PAYLOAD.
REQ-016 IDLE SHALL go to ID when tms_i=1 and tdi_i=1; tdi_i=0 or tms_i=0 in IDLE SHALL leave the FSM in IDLE.
REQ-017 ID, DNR and LEN SHALL each sample exactly their field width, then advance; LEN SHALL go to PAYLOAD if LEN!=0, else to IDLE with completion.
REQ-018 PAYLOAD SHALL sample exactly LEN bits, then return to IDLE with completion.
REQ-019 At packet start, the payload shadow register SHALL be cleared; each payload bit SHALL shift in at the LSB (shift left).
REQ-020 If LEN < payload_width_p, the upper bits SHALL be zero; if LEN > payload_width_p, only the last payload_width_p bits SHALL be kept.
REQ-021 Completion with ID==node_id_p and DNR=1 SHALL load data_o from the shadow and pulse data_v_o in the cycle after the last bit is sampled.
REQ-022 Completion with ID==node_id_p and DNR=0 SHALL clear data_o to 0 and pulse node_reset_o in the cycle after the last bit is sampled; payload bits, if any, SHALL be consumed and discarded.
REQ-023 Completion with a non-matching ID SHALL consume the full packet and produce no output change.
REQ-024 The FSM SHALL be in IDLE in the cycle data_v_o/node_reset_o is high, so a start bit in that cycle begins the next packet (back-to-back, zero gap).
REQ-025 tms_i=0 in any non-IDLE state SHALL abort: go to IDLE, no pulses, data_o unchanged, abort_cnt_o +1 saturating at 255.
REQ-026 data_v_o and node_reset_o SHALL never be high in the same cycle.

Reset
REQ-027 reset_i SHALL, on the next edge, force IDLE, data_o=0, data_v_o=0, node_reset_o=0, busy_o=0, abort_cnt_o=0, and clear the shadow and counters.
REQ-028 reset_i SHALL take priority over every in-flight packet and over abort counting; a packet interrupted by reset SHALL NOT be counted as aborted.

Structure
REQ-029 A shared package bsg_tag_rx_pkg SHALL hold the FSM state enum and the default width constants.
REQ-030 The block SHALL instantiate one sub-module, bsg_tag_rx_field_counter: a loadable down-counter used for the ID, LEN and PAYLOAD bit counts, with a zero flag.

Verification (node_id_p=3, id_width_p=4, len_width_p=6, payload_width_p=8)
REQ-031 Send ID=3, DNR=1, LEN=8, payload 0xA5 (20 bits) -> data_v_o high exactly one cycle, the cycle after bit 20; data_o=0xA5; busy_o high for 19 cycles.
REQ-032 Send ID=5, DNR=1, LEN=8, payload 0xFF -> no pulses; data_o keeps its prior value; a following ID=3 packet with payload 0x11 is accepted -> data_o=0x11.
REQ-033 Send LEN=4, payload 1011 -> data_o=0x0B; then LEN=12, payload 0xF3C -> data_o=0x3C.
REQ-034 Preload data_o=0x5A, then send ID=3, DNR=0, LEN=0 -> node_reset_o pulses one cycle after the last LEN bit; data_o=0x00.
REQ-035 Drop tms_i during payload bit 3 -> abort_cnt_o=1, no pulses, data_o unchanged; 300 aborts -> abort_cnt_o=255.
REQ-036 Assert reset_i mid-LEN -> next cycle all outputs are 0; then two back-to-back packets with payloads 0x01 and 0x02 and no idle gap -> two data_v_o pulses, 20 cycles apart.
